// File: rtl/i_ram_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
// master = loader side, slave = UART receiver / RAM side.
interface i_ram_loader_if #(
    parameter int addr_width = 12,
    parameter int data_width = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [addr_width-1:0] ram_w_addr;
    logic [data_width-1:0] ram_din;
    logic                  ram_w_en;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, ram_w_addr, ram_din, ram_w_en
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, ram_w_addr, ram_din, ram_w_en
    );
endinterface

// File: rtl/i_ram_loader.sv
// Boot loader: parses A5/len/words/checksum frames into sequential I-RAM writes, one write 1 cycle after each low byte.
// Accepts a byte every cycle once out of reset (rx_ready never drops); a stalled frame errors out after `timeout` idle cycles.
module i_ram_loader #(
    parameter int addr_width = 12,
    parameter int data_width = 16,
    parameter int timeout    = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    i_ram_loader_if.master      bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [addr_width:0] words_written
);

    localparam int          tmr_w   = $clog2(timeout + 1);
    localparam logic [16:0] max_len = 17'(64'd1 << addr_width);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK, DONE_ST, ERR
    } state_t;

    state_t                state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            sum_q, sum_d;
    logic [tmr_w-1:0]      tmr_q, tmr_d;
    logic                  wen_q, wen_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic [data_width-1:0] din_q, din_d;
    logic [addr_width:0]   ww_q, ww_d;
    logic                  err_q, err_d;

    logic                  acc;
    logic                  in_frame;
    logic                  timed_out;
    logic [15:0]           n_len;
    logic [addr_width:0]   ww_inc;

    always_comb begin
        state_d   = state_q;
        rdy_d     = 1'b1;
        len_d     = len_q;
        hi_d      = hi_q;
        sum_d     = sum_q;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        din_d     = din_q;
        ww_d      = ww_q;
        err_d     = err_q;

        acc       = bus.rx_valid && rdy_q;
        in_frame  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DAT_HI) ||
                    (state_q == DAT_LO) || (state_q == CHK);
        timed_out = in_frame && !acc && (tmr_q == tmr_w'(timeout - 1));
        tmr_d     = (acc || !in_frame) ? '0 : tmr_q + tmr_w'(1);
        n_len     = {len_q[15:8], bus.rx_data};
        ww_inc    = ww_q + 1'b1;

        case (state_q)
            // DONE_ST and ERR last one cycle; a byte landing there is parsed as if idle so none is lost.
            IDLE, DONE_ST, ERR: begin
                state_d = IDLE;
                if (acc && bus.rx_data == 8'hA5) begin
                    state_d = LEN_HI;
                    err_d   = 1'b0;
                    ww_d    = '0;
                    sum_d   = '0;
                end
            end
            LEN_HI: begin
                if (acc) begin
                    len_d[15:8] = bus.rx_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (acc) begin
                    len_d = n_len;
                    if ({1'b0, n_len} > max_len) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (n_len == 16'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_HI: begin
                if (acc) begin
                    hi_d    = bus.rx_data;
                    sum_d   = sum_q + bus.rx_data;
                    state_d = DAT_LO;
                end
            end
            DAT_LO: begin
                if (acc) begin
                    sum_d   = sum_q + bus.rx_data;
                    wen_d   = 1'b1;
                    din_d   = {hi_q, bus.rx_data};
                    waddr_d = ww_q[addr_width-1:0];
                    ww_d    = ww_inc;
                    state_d = (32'(ww_inc) == 32'(len_q)) ? CHK : DAT_HI;
                end
            end
            CHK: begin
                if (acc) begin
                    if (bus.rx_data == sum_q) begin
                        state_d = DONE_ST;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timed_out) begin
            state_d = ERR;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            len_q   <= '0;
            hi_q    <= '0;
            sum_q   <= '0;
            tmr_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
            ww_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            sum_q   <= sum_d;
            tmr_q   <= tmr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            ww_q    <= ww_d;
            err_q   <= err_d;
        end
    end

    assign bus.rx_ready   = rdy_q;
    assign bus.ram_w_en   = wen_q;
    assign bus.ram_w_addr = waddr_q;
    assign bus.ram_din    = din_q;
    assign cpu_hold       = in_frame;
    assign done           = (state_q == DONE_ST);
    assign err            = err_q;
    assign words_written  = ww_q;

endmodule

// File: tb/tb_i_ram_loader.sv
// Directed bench for i_ram_loader (addr_width=12, timeout=16); outputs sampled 1 time unit after the rising edge.
module tb_i_ram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_hold, done, err;
    logic [12:0] words_written;
    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;

    i_ram_loader_if #(.addr_width(12), .data_width(16)) bus_if ();

    i_ram_loader #(.addr_width(12), .data_width(16), .timeout(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.ram_w_en) wr_cnt++;
        if (done) done_cnt++;
    end

    task automatic send(input logic [7:0] b);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus_if.rx_ready, bus_if.ram_w_en, cpu_hold, done, err, bus_if.ram_w_addr, bus_if.ram_din, words_written} !== 47'd0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b wen=%b hold=%b done=%b err=%b addr=%h din=%h ww=%h want all 0",
                     bus_if.rx_ready, bus_if.ram_w_en, cpu_hold, done, err, bus_if.ram_w_addr, bus_if.ram_din, words_written);
        end
        rst = 1'b0;
        idle(1);
        total++;
        if ({bus_if.rx_ready, cpu_hold} !== 2'b10) begin
            bad++;
            $display("FAIL ready_after_reset got rdy=%b hold=%b want 1 0", bus_if.rx_ready, cpu_hold);
        end
    endtask

    task automatic test_basic;
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        send(8'hA5);
        total++;
        if (cpu_hold !== 1'b1) begin bad++; $display("FAIL basic_hold_len got %b want 1", cpu_hold); end
        send(8'h00); send(8'h02); send(8'h12);
        total++;
        if (bus_if.ram_w_en !== 1'b0) begin bad++; $display("FAIL basic_no_early_write got %b want 0", bus_if.ram_w_en); end
        send(8'h34);
        total++;
        if ({bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written} !== {1'b1, 12'h000, 16'h1234, 13'd1}) begin
            bad++;
            $display("FAIL basic_write0 got wen=%b addr=%h din=%h ww=%0d want 1 000 1234 1",
                     bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written);
        end
        send(8'hAB);
        total++;
        if (bus_if.ram_w_en !== 1'b0) begin bad++; $display("FAIL basic_single_cycle_wen got %b want 0", bus_if.ram_w_en); end
        send(8'hCD);
        total++;
        if ({bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written, cpu_hold} !== {1'b1, 12'h001, 16'hABCD, 13'd2, 1'b1}) begin
            bad++;
            $display("FAIL basic_write1 got wen=%b addr=%h din=%h ww=%0d hold=%b want 1 001 abcd 2 1",
                     bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written, cpu_hold);
        end
        send(8'hBE);
        total++;
        if ({done, err, cpu_hold} !== 3'b100) begin
            bad++;
            $display("FAIL basic_done got done=%b err=%b hold=%b want 1 0 0", done, err, cpu_hold);
        end
        idle(1);
        total++;
        if ({done, cpu_hold, words_written} !== {1'b0, 1'b0, 13'd2} || wr_cnt - w0 != 2 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL basic_after got done=%b hold=%b ww=%0d writes=%0d dones=%0d want 0 0 2 2 1",
                     done, cpu_hold, words_written, wr_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_bad_checksum;
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        send(8'hBF);
        total++;
        if ({err, done, cpu_hold, bus_if.ram_din} !== {3'b100, 16'hABCD} || wr_cnt - w0 != 2) begin
            bad++;
            $display("FAIL badsum_err got err=%b done=%b hold=%b din=%h writes=%0d want 1 0 0 abcd 2",
                     err, done, cpu_hold, bus_if.ram_din, wr_cnt - w0);
        end
        idle(3);
        total++;
        if (err !== 1'b1 || done_cnt != d0) begin
            bad++;
            $display("FAIL badsum_sticky got err=%b dones=%0d want 1 0", err, done_cnt - d0);
        end
    endtask

    task automatic test_zero_len;
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        send(8'hA5);
        total++;
        if ({err, cpu_hold} !== 2'b01) begin bad++; $display("FAIL zero_sync_clears_err got err=%b hold=%b want 0 1", err, cpu_hold); end
        send(8'h00); send(8'h00);
        total++;
        if ({cpu_hold, bus_if.ram_w_en, words_written} !== {1'b1, 1'b0, 13'd0}) begin
            bad++;
            $display("FAIL zero_chk got hold=%b wen=%b ww=%0d want 1 0 0", cpu_hold, bus_if.ram_w_en, words_written);
        end
        send(8'h00);
        total++;
        if ({done, err, cpu_hold} !== 3'b100 || wr_cnt != w0) begin
            bad++;
            $display("FAIL zero_done got done=%b err=%b hold=%b writes=%0d want 1 0 0 0", done, err, cpu_hold, wr_cnt - w0);
        end
        idle(2);
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL zero_one_pulse got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_too_long;
        int w0;
        w0 = wr_cnt;
        send(8'hA5); send(8'h10); send(8'h01);
        total++;
        if ({err, cpu_hold, done} !== 3'b100) begin
            bad++;
            $display("FAIL toolong_err got err=%b hold=%b done=%b want 1 0 0", err, cpu_hold, done);
        end
        idle(2);
        total++;
        if (wr_cnt != w0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL toolong_nowrite got writes=%0d hold=%b want 0 0", wr_cnt - w0, cpu_hold);
        end
    endtask

    task automatic test_garbage_then_frame;
        send(8'h00);
        total++;
        if (cpu_hold !== 1'b0) begin bad++; $display("FAIL garbage_00 hold got %b want 0", cpu_hold); end
        send(8'hFF); send(8'h5A);
        total++;
        if ({cpu_hold, err} !== 2'b01) begin bad++; $display("FAIL garbage_ignored got hold=%b err=%b want 0 1", cpu_hold, err); end
        send(8'hA5); send(8'h00); send(8'h01); send(8'hA5); send(8'h5A);
        total++;
        if ({bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written, err} !== {1'b1, 12'h000, 16'hA55A, 13'd1, 1'b0}) begin
            bad++;
            $display("FAIL garbage_write got wen=%b addr=%h din=%h ww=%0d err=%b want 1 000 a55a 1 0",
                     bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written, err);
        end
        send(8'hFF);
        total++;
        if ({done, err} !== 2'b10) begin bad++; $display("FAIL garbage_done got done=%b err=%b want 1 0", done, err); end
        idle(1);
    endtask

    task automatic test_timeout;
        int w0;
        w0 = wr_cnt;
        send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
        idle(15);
        total++;
        if ({err, cpu_hold} !== 2'b01) begin bad++; $display("FAIL timeout_early got err=%b hold=%b want 0 1", err, cpu_hold); end
        idle(1);
        total++;
        if ({err, cpu_hold} !== 2'b10 || wr_cnt != w0) begin
            bad++;
            $display("FAIL timeout_fire got err=%b hold=%b writes=%0d want 1 0 0", err, cpu_hold, wr_cnt - w0);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_frame;
        send(8'hA5); send(8'h00); send(8'h02); send(8'h11); send(8'h22);
        total++;
        if ({bus_if.ram_w_en, bus_if.ram_din, words_written} !== {1'b1, 16'h1122, 13'd1}) begin
            bad++;
            $display("FAIL rstmid_prewrite got wen=%b din=%h ww=%0d want 1 1122 1", bus_if.ram_w_en, bus_if.ram_din, words_written);
        end
        send(8'h33);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus_if.rx_ready, bus_if.ram_w_en, cpu_hold, done, err, bus_if.ram_w_addr, bus_if.ram_din, words_written} !== 47'd0) begin
            bad++;
            $display("FAIL rstmid_async got rdy=%b wen=%b hold=%b done=%b err=%b addr=%h din=%h ww=%h want all 0",
                     bus_if.rx_ready, bus_if.ram_w_en, cpu_hold, done, err, bus_if.ram_w_addr, bus_if.ram_din, words_written);
        end
        #2;
        rst = 1'b0;
        idle(2);
        send(8'hA5); send(8'h00); send(8'h01); send(8'h44); send(8'h55);
        total++;
        if ({bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written} !== {1'b1, 12'h000, 16'h4455, 13'd1}) begin
            bad++;
            $display("FAIL rstmid_reload got wen=%b addr=%h din=%h ww=%0d want 1 000 4455 1",
                     bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written);
        end
        send(8'h99);
        total++;
        if ({done, err} !== 2'b10) begin bad++; $display("FAIL rstmid_done got done=%b err=%b want 1 0", done, err); end
        idle(1);
    endtask

    task automatic test_max_len;
        int         w0;
        logic [7:0] s;
        w0 = wr_cnt;
        s  = 8'h00;
        send(8'hA5); send(8'h10); send(8'h00);
        for (int i = 0; i < 4096; i++) begin
            send(8'(i >> 8));
            send(8'(i));
            s = s + 8'(i >> 8) + 8'(i);
        end
        total++;
        if ({bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written, cpu_hold} !== {1'b1, 12'hFFF, 16'h0FFF, 13'h1000, 1'b1}) begin
            bad++;
            $display("FAIL max_last_write got wen=%b addr=%h din=%h ww=%h hold=%b want 1 fff 0fff 1000 1",
                     bus_if.ram_w_en, bus_if.ram_w_addr, bus_if.ram_din, words_written, cpu_hold);
        end
        send(s);
        total++;
        if ({done, err} !== 2'b10 || wr_cnt - w0 != 4096) begin
            bad++;
            $display("FAIL max_done got done=%b err=%b writes=%0d want 1 0 4096", done, err, wr_cnt - w0);
        end
        idle(1);
    endtask

    initial begin
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_zero_len();
        test_too_long();
        test_garbage_then_frame();
        test_timeout();
        test_reset_mid_frame();
        test_max_len();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i_ram_loader.md
Name: i_ram_loader

Overview:
Boot-time controller that fills the instruction RAM write port from a byte stream (UART receiver).
- Parses a framed image: sync byte, 16-bit word count, big-endian 16-bit words, 8-bit checksum.
- Issues sequential single-cycle RAM writes starting at address 0.
- Holds the CPU off the fetch path while loading, and reports done or error.

Parameters:
- addr_width, 12, instruction RAM address width; maximum image is 2^addr_width words.
- data_width, 16, instruction word width; fixed at 16, two bytes per word.
- timeout, 1000000, maximum number of clk cycles allowed between accepted bytes while a frame is in progress.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle.
- ram_w_addr  output  addr_width  RAM write address.
- ram_din  output  data_width  RAM write data.
- ram_w_en  output  1  RAM write strobe, one cycle per word.
- cpu_hold  output  1  CPU must stall or stay in reset while high.
- done  output  1  one-cycle pulse on a good image.
- err  output  1  sticky error flag.
- words_written  output  addr_width+1  count of words written in the current frame.

Behaviour:
- Reset/ready:
  - Reset is asynchronous, active-high.
  - On reset: state=IDLE; ram_w_en, cpu_hold, done, err = 0; ram_w_addr, ram_din, words_written = 0; rx_ready = 0.
  - rx_ready is 1 in every state after reset is released.
  - A byte is accepted when rx_valid && rx_ready.
- States:
  - IDLE: byte 0xA5 → LEN_HI, clear err, clear words_written, clear checksum. Any other byte is discarded.
  - LEN_HI: store byte as N[15:8] → LEN_LO.
  - LEN_LO: store byte as N[7:0].
    - N > 2^addr_width → ERR.
    - N == 0 → CHK.
    - Otherwise → DAT_HI.
  - DAT_HI: latch high byte → DAT_LO.
  - DAT_LO: form word {hi, lo}.
    - Next cycle: ram_w_en=1, ram_din=word, ram_w_addr=words_written[addr_width-1:0].
    - words_written increments in that same cycle.
    - If incremented count == N → CHK, else → DAT_HI.
  - CHK: compare byte to running sum.
    - Equal → DONE_ST with done=1 for exactly one cycle → IDLE.
    - Not equal → ERR.
  - ERR: set err=1 → IDLE. err stays high until the next accepted 0xA5.
- Checksum:
  - 8-bit sum, modulo 256, of all data bytes only.
  - Sync and length bytes are excluded.
- cpu_hold:
  - 1 in LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK, and during the cycle of the final write.
  - 0 in IDLE, DONE_ST, ERR.
- Timeout:
  - A counter runs in every state except IDLE and is cleared on each accepted byte.
  - Reaching timeout → ERR; cpu_hold drops on the next cycle.
- Write semantics:
  - Already-written words are not rolled back on error.
  - With N = 2^addr_width, the last write goes to address 2^addr_width−1 and there is no wrap.
- Throughput: back-to-back bytes (rx_valid held high) are accepted every cycle. Write latency is 1 cycle after the low byte.
- 0xA5 mid-frame is treated as ordinary data; no resync.
- Reset mid-frame: immediately returns to the reset values. A partial image stays in RAM.

Test Plan:
- Frame A5 00 02 12 34 AB CD BE, back-to-back → writes 0x1234@0, 0xABCD@1, each 1 cycle after its low byte; done pulse; err=0; words_written=2; cpu_hold low after done.
- Same frame with checksum 0xBF → err=1, no done; both words still written; the next A5 clears err.
- Frame A5 10 01 (N=4097, addr_width=12) → err=1 straight after LEN_LO; no ram_w_en.
- Frame A5 00 00 00 → no writes; done pulse.
- Bytes 00 FF 5A before A5 → ignored; cpu_hold stays 0; the frame after them loads normally.
- Gaps: timeout=16; stall 16 cycles after DAT_HI → err=1, cpu_hold=0. Separately, assert rst mid-DAT_LO → all outputs return to 0 asynchronously; the next frame loads from address 0.
